// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register bank between NREQ requesters.
// Each grant writes the winner's byte, then the bank is held stable for HOLD cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for any req; picks winner from ptr, latches sel
// S_WRITE | one cycle, gnt one-hot at sel, q loaded on closing edge
// S_HOLD  | q held stable, down-counter runs to 0, then back to IDLE
module dff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [1:0]            q_owner,
  output logic                  q_valid,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  ptr;
  logic [1:0]  sel;
  logic [3:0]  cnt;
  logic [1:0]  winner;
  logic [1:0]  idx;
  logic        found;

  // First set request at ptr, ptr+1, ... wrapping modulo 4.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ptr     <= 2'd0;
      sel     <= 2'd0;
      cnt     <= 4'd0;
      gnt     <= '0;
      q       <= '0;
      q_owner <= 2'd0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          gnt <= '0;
          if (|req) begin
            sel   <= winner;
            gnt   <= NREQ'(1) << winner;
            busy  <= 1'b1;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Grant is committed: write regardless of req[sel] this cycle.
          gnt     <= '0;
          q       <= wdata[sel*WIDTH +: WIDTH];
          q_owner <= sel;
          q_valid <= 1'b1;
          ptr     <= sel + 2'd1;
          if (HOLD > 0) begin
            cnt   <= 4'(HOLD - 1);
            state <= S_HOLD;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_HOLD: begin
          gnt <= '0;
          if (cnt == 4'd0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: directed vector table, hand-written corner sequences,
// and random traffic against a timeline model, on a HOLD=2 and a HOLD=0 instance.
module tb_dff_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;

  logic [3:0] gnt_a, gnt_b;
  logic [7:0] q_a, q_b;
  logic [1:0] own_a, own_b;
  logic       val_a, val_b, busy_a, busy_b;

  always #5 clk = ~clk;

  dff_bank_arbiter #(.NREQ(4), .WIDTH(8), .HOLD(2)) dut_a (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt_a), .q(q_a), .q_owner(own_a), .q_valid(val_a), .busy(busy_a));

  dff_bank_arbiter #(.NREQ(4), .WIDTH(8), .HOLD(0)) dut_b (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt_b), .q(q_b), .q_owner(own_b), .q_valid(val_b), .busy(busy_b));

  int errors = 0;
  int checks = 0;
  int t = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  // Timeline model: a grant decided in cycle k makes k+1 the write cycle
  // and k+2+hold the first cycle that may arbitrate again.
  int         hold_of[2] = '{2, 0};
  int         m_free[2]  = '{0, 0};
  int         m_wcyc[2]  = '{-1, -1};
  int         m_sel[2]   = '{0, 0};
  int         m_ptr[2]   = '{0, 0};
  logic [7:0] m_q[2]     = '{8'h00, 8'h00};
  int         m_owner[2] = '{0, 0};
  logic       m_valid[2] = '{1'b0, 1'b0};

  task automatic model_step(input int d, input logic r, input logic [3:0] rq, input logic [31:0] wd);
    if (r) begin
      m_free[d] = t + 1; m_wcyc[d] = -1; m_ptr[d] = 0;
      m_q[d] = 8'h00; m_owner[d] = 0; m_valid[d] = 1'b0;
    end else begin
      if (t == m_wcyc[d]) begin
        m_q[d]     = wd[m_sel[d]*8 +: 8];
        m_owner[d] = m_sel[d];
        m_valid[d] = 1'b1;
        m_ptr[d]   = (m_sel[d] + 1) % 4;
      end
      if (t >= m_free[d] && rq != 4'd0) begin
        for (int i = 0; i < 4; i++) begin
          if (rq[(m_ptr[d] + i) % 4]) begin
            m_sel[d] = (m_ptr[d] + i) % 4;
            break;
          end
        end
        m_wcyc[d] = t + 1;
        m_free[d] = t + 2 + hold_of[d];
      end
    end
  endtask

  task automatic model_cmp(input int d);
    logic [3:0] eg;
    logic [3:0] g;
    logic [7:0] qq;
    logic [1:0] o;
    logic       v, b;
    eg = (m_wcyc[d] == t) ? (4'b0001 << m_sel[d]) : 4'b0000;
    g  = d == 0 ? gnt_a  : gnt_b;
    qq = d == 0 ? q_a    : q_b;
    o  = d == 0 ? own_a  : own_b;
    v  = d == 0 ? val_a  : val_b;
    b  = d == 0 ? busy_a : busy_b;
    chk($sformatf("model_gnt[h%0d]", hold_of[d]), {28'd0, g}, {28'd0, eg});
    chk($sformatf("model_q[h%0d]", hold_of[d]), {24'd0, qq}, {24'd0, m_q[d]});
    chk($sformatf("model_owner[h%0d]", hold_of[d]), {30'd0, o}, 32'(m_owner[d]));
    chk($sformatf("model_valid[h%0d]", hold_of[d]), {31'd0, v}, {31'd0, m_valid[d]});
    chk($sformatf("model_busy[h%0d]", hold_of[d]), {31'd0, b}, {31'd0, (t < m_free[d])});
  endtask

  // Apply one cycle of inputs; afterwards outputs show the following cycle.
  task automatic cycle(input logic r, input logic [3:0] rq, input logic [31:0] wd);
    @(negedge clk);
    rst = r; req = rq; wdata = wd;
    model_step(0, r, rq, wd);
    model_step(1, r, rq, wd);
    @(posedge clk);
    #1;
    t++;
    model_cmp(0);
    model_cmp(1);
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [1:0]  owner;
    logic        valid;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] wd,
                     input logic [3:0] g, input logic [7:0] qq, input logic [1:0] o,
                     input logic v, input logic b);
    vec_t x;
    x.rst = r; x.req = rq; x.wdata = wd; x.gnt = g;
    x.q = qq; x.owner = o; x.valid = v; x.busy = b;
    vecs.push_back(x);
  endtask

  localparam logic [31:0] WD  = 32'h44332211;
  localparam logic [31:0] WA5 = 32'h44A52211;
  localparam logic [31:0] W5A = 32'h44335A11;

  initial begin
    logic [31:0] rnd;
    rst = 1'b1; req = 4'd0; wdata = WD;

    // reset, then IDLE
    add(1, 4'b0000, WD, 4'b0000, 8'h00, 0, 0, 0);
    add(1, 4'b0000, WD, 4'b0000, 8'h00, 0, 0, 0);
    add(1, 4'b0000, WD, 4'b0000, 8'h00, 0, 0, 0);
    add(0, 4'b0000, WD, 4'b0000, 8'h00, 0, 0, 0);
    // all four requesting: order 0,1,2,3,0 spaced 4 cycles
    add(0, 4'b1111, WD, 4'b0001, 8'h00, 0, 0, 1);
    add(0, 4'b1111, WD, 4'b0000, 8'h11, 0, 1, 1);
    add(0, 4'b1111, WD, 4'b0000, 8'h11, 0, 1, 1);
    add(0, 4'b1111, WD, 4'b0000, 8'h11, 0, 1, 0);
    add(0, 4'b1111, WD, 4'b0010, 8'h11, 0, 1, 1);
    add(0, 4'b1111, WD, 4'b0000, 8'h22, 1, 1, 1);
    add(0, 4'b1111, WD, 4'b0000, 8'h22, 1, 1, 1);
    add(0, 4'b1111, WD, 4'b0000, 8'h22, 1, 1, 0);
    add(0, 4'b1111, WD, 4'b0100, 8'h22, 1, 1, 1);
    add(0, 4'b1111, WD, 4'b0000, 8'h33, 2, 1, 1);
    add(0, 4'b1111, WD, 4'b0000, 8'h33, 2, 1, 1);
    add(0, 4'b1111, WD, 4'b0000, 8'h33, 2, 1, 0);
    add(0, 4'b1111, WD, 4'b1000, 8'h33, 2, 1, 1);
    add(0, 4'b1111, WD, 4'b0000, 8'h44, 3, 1, 1);
    add(0, 4'b1111, WD, 4'b0000, 8'h44, 3, 1, 1);
    add(0, 4'b1111, WD, 4'b0000, 8'h44, 3, 1, 0);
    add(0, 4'b1111, WD, 4'b0001, 8'h44, 3, 1, 1);
    add(0, 4'b0000, WD, 4'b0000, 8'h11, 0, 1, 1);
    add(0, 4'b0000, WD, 4'b0000, 8'h11, 0, 1, 1);
    add(0, 4'b0000, WD, 4'b0000, 8'h11, 0, 1, 0);
    // single requester 2 with 0xA5
    add(0, 4'b0100, WA5, 4'b0100, 8'h11, 0, 1, 1);
    add(0, 4'b0000, WA5, 4'b0000, 8'hA5, 2, 1, 1);
    add(0, 4'b0000, WA5, 4'b0000, 8'hA5, 2, 1, 1);
    add(0, 4'b0000, WA5, 4'b0000, 8'hA5, 2, 1, 0);
    add(0, 4'b0000, WA5, 4'b0000, 8'hA5, 2, 1, 0);
    // after grant to 2 the search starts at 3 and wraps to 0
    add(0, 4'b0101, WD, 4'b0001, 8'hA5, 2, 1, 1);
    add(0, 4'b0000, WD, 4'b0000, 8'h11, 0, 1, 1);
    add(0, 4'b0000, WD, 4'b0000, 8'h11, 0, 1, 1);
    add(0, 4'b0000, WD, 4'b0000, 8'h11, 0, 1, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].req, vecs[i].wdata);
      chk($sformatf("vec%0d_gnt", i), {28'd0, gnt_a}, {28'd0, vecs[i].gnt});
      chk($sformatf("vec%0d_q", i), {24'd0, q_a}, {24'd0, vecs[i].q});
      chk($sformatf("vec%0d_owner", i), {30'd0, own_a}, {30'd0, vecs[i].owner});
      chk($sformatf("vec%0d_valid", i), {31'd0, val_a}, {31'd0, vecs[i].valid});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy_a}, {31'd0, vecs[i].busy});
    end

    // committed grant: req[1] dropped in WRITE, req[3] pulsed in HOLD
    cycle(0, 4'b0010, W5A);
    chk("commit_gnt", {28'd0, gnt_a}, 32'h2);
    cycle(0, 4'b0000, W5A);
    chk("commit_q", {24'd0, q_a}, 32'h5A);
    chk("commit_owner", {30'd0, own_a}, 32'd1);
    cycle(0, 4'b1000, W5A);
    chk("hold_req_gnt0", {28'd0, gnt_a}, 32'h0);
    cycle(0, 4'b0000, W5A);
    chk("hold_req_gnt1", {28'd0, gnt_a}, 32'h0);
    chk("hold_end_busy", {31'd0, busy_a}, 32'd0);
    cycle(0, 4'b0000, W5A);
    chk("withdrawn_gnt", {28'd0, gnt_a}, 32'h0);

    // reset in the first HOLD cycle
    cycle(0, 4'b1111, WD);
    chk("rsthold_gnt", {28'd0, gnt_a}, 32'h4);
    cycle(0, 4'b1111, WD);
    chk("rsthold_q_pre", {24'd0, q_a}, 32'h33);
    cycle(1, 4'b1111, WD);
    chk("rsthold_q", {24'd0, q_a}, 32'h0);
    chk("rsthold_valid", {31'd0, val_a}, 32'd0);
    chk("rsthold_busy", {31'd0, busy_a}, 32'd0);
    cycle(0, 4'b1111, WD);
    chk("rsthold_regrant", {28'd0, gnt_a}, 32'h1);

    // reset coinciding with the WRITE closing edge wins
    cycle(1, 4'b1111, WD);
    chk("rstwrite_q", {24'd0, q_a}, 32'h0);
    chk("rstwrite_valid", {31'd0, val_a}, 32'd0);
    chk("rstwrite_gnt", {28'd0, gnt_a}, 32'h0);
    cycle(0, 4'b0000, WD);

    // random traffic, both instances against the model
    for (int n = 0; n < 800; n++) begin
      logic       r;
      logic [3:0] rq;
      r   = ($urandom_range(0, 59) == 0);
      rnd = $urandom();
      rq  = ($urandom_range(0, 3) == 0) ? 4'd0 : rnd[3:0];
      cycle(r, rq, $urandom());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
